// File: rtl/pll_ctrl_defs.sv
// Shared definitions for the PLL lock sequencer: state encodings and output decode.
package pll_ctrl_defs;

    localparam int unsigned ST_W = 3;

    localparam logic [ST_W-1:0] PLL_RST   = 3'd0;
    localparam logic [ST_W-1:0] WAIT_LOCK = 3'd1;
    localparam logic [ST_W-1:0] STABLE    = 3'd2;
    localparam logic [ST_W-1:0] RUN       = 3'd3;
    localparam logic [ST_W-1:0] FAULT     = 3'd4;

    typedef struct packed {
        logic pll_resetb;
        logic sys_reset_n;
        logic pll_ready;
        logic fault;
    } seq_out_t;

    // Level outputs implied by a state; registered against the next state.
    function automatic seq_out_t decode_outputs(input logic [ST_W-1:0] st);
        seq_out_t o;
        o = '0;
        case (st)
            WAIT_LOCK, STABLE: o.pll_resetb = 1'b1;
            RUN: begin
                o.pll_resetb  = 1'b1;
                o.sys_reset_n = 1'b1;
                o.pll_ready   = 1'b1;
            end
            FAULT:   o.fault = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with a configurable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: pulses RESETB, qualifies LOCK, releases system reset,
// retries on timeout, and latches a fault after the retry budget is spent.
module pll_lock_sequencer
    import pll_ctrl_defs::*;
#(
    parameter int unsigned PLL_RESET_CYCLES    = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 24000,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned CNT_W               = 16
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                pll_lock_async,
    input  logic                                relock_req,
    output logic                                pll_resetb,
    output logic                                sys_reset_n,
    output logic                                pll_ready,
    output logic                                lock_lost,
    output logic                                fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]    retry_count
);

    localparam int unsigned RC_W = $clog2(MAX_RETRIES + 1);

    logic              lock_s;
    logic [ST_W-1:0]   state_q,     state_d;
    logic [CNT_W-1:0]  tmo_cnt_q,   tmo_cnt_d;
    logic [CNT_W-1:0]  stb_cnt_q,   stb_cnt_d;
    logic [RC_W-1:0]   retry_q,     retry_d;
    logic              lock_lost_q, lock_lost_d;
    seq_out_t          out_q,       out_d;

    logic [CNT_W-1:0]  tmo_inc;
    logic [CNT_W-1:0]  stb_inc;
    logic              timeout;
    logic              stb_done;

    sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
        .clk   (clock),
        .rst_n (reset_n),
        .d     (pll_lock_async),
        .q     (lock_s)
    );

    // Counts include the current cycle, so a compare on the increment fires on the Nth cycle.
    assign tmo_inc  = tmo_cnt_q + CNT_W'(1);
    assign stb_inc  = stb_cnt_q + CNT_W'(1);
    assign timeout  = (tmo_inc >= CNT_W'(LOCK_TIMEOUT_CYCLES));
    assign stb_done = lock_s && (stb_inc >= CNT_W'(LOCK_STABLE_CYCLES));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= PLL_RST;
            tmo_cnt_q   <= '0;
            stb_cnt_q   <= '0;
            retry_q     <= '0;
            lock_lost_q <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            tmo_cnt_q   <= tmo_cnt_d;
            stb_cnt_q   <= stb_cnt_d;
            retry_q     <= retry_d;
            lock_lost_q <= lock_lost_d;
            out_q       <= out_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tmo_cnt_d   = tmo_cnt_q;
        stb_cnt_d   = stb_cnt_q;
        retry_d     = retry_q;
        lock_lost_d = 1'b0;

        case (state_q)
            PLL_RST: begin
                stb_cnt_d = '0;
                if (tmo_inc >= CNT_W'(PLL_RESET_CYCLES)) begin
                    state_d   = WAIT_LOCK;
                    tmo_cnt_d = '0;
                end else begin
                    tmo_cnt_d = tmo_inc;
                end
            end
            WAIT_LOCK, STABLE: begin
                // Timeout runs across lock glitches; stable count restarts on any drop.
                tmo_cnt_d = tmo_inc;
                stb_cnt_d = lock_s ? stb_inc : '0;
                if (stb_done) begin
                    state_d   = RUN;
                    tmo_cnt_d = '0;
                    stb_cnt_d = '0;
                end else if (timeout) begin
                    tmo_cnt_d = '0;
                    stb_cnt_d = '0;
                    if (retry_q < RC_W'(MAX_RETRIES)) begin
                        retry_d = retry_q + RC_W'(1);
                        state_d = PLL_RST;
                    end else begin
                        state_d = FAULT;
                    end
                end else begin
                    state_d = lock_s ? STABLE : WAIT_LOCK;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    lock_lost_d = 1'b1;
                    state_d     = PLL_RST;
                    retry_d     = '0;
                end else if (relock_req) begin
                    state_d = PLL_RST;
                    retry_d = '0;
                end
            end
            FAULT: begin
                if (relock_req) begin
                    state_d = PLL_RST;
                    retry_d = '0;
                end
            end
            default: begin
                state_d   = PLL_RST;
                tmo_cnt_d = '0;
                stb_cnt_d = '0;
                retry_d   = '0;
            end
        endcase

        out_d = decode_outputs(state_d);
    end

    assign pll_resetb  = out_q.pll_resetb;
    assign sys_reset_n = out_q.sys_reset_n;
    assign pll_ready   = out_q.pll_ready;
    assign fault       = out_q.fault;
    assign lock_lost   = lock_lost_q;
    assign retry_count = retry_q;

endmodule
